// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled flash-side SPI responder serving READ (0x03)
// and dual-output FAST READ (0x3B) bursts from a synchronous 16-bit word memory.
`default_nettype none

module spi_flash_responder #(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_io0_i,
  output logic              spi_io0_o,
  output logic              spi_io0_oe,
  input  logic              spi_io1_i,
  output logic              spi_io1_o,
  output logic              spi_io1_oe,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  logic cs_meta, cs_sync, cs_prev;
  logic sclk_meta, sclk_sync, sclk_prev;
  logic io0_meta, io0_sync;
  logic io1_meta, io1_sync;

  logic [2:0]        state;
  logic [4:0]        bit_cnt;
  logic [6:0]        cmd_sr;
  logic [MEM_AW-1:0] addr_sr;
  logic              dual;
  logic              odd_first;
  logic [MEM_AW-1:0] word_addr;
  logic [15:0]       prefetch;
  logic [15:0]       shift;
  logic [3:0]        remain;
  logic              rd_pending;

  logic              sclk_rise, sclk_fall, cs_fall;
  logic [7:0]        cmd_next;
  logic [MEM_AW:0]   addr_next;
  logic [MEM_AW-1:0] word_next;
  logic [15:0]       load_word;
  logic [3:0]        load_remain;

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  // Only a fresh CS falling edge starts a transaction, so a burst already in
  // flight when reset releases is ignored until CS cycles.
  assign cs_fall   = cs_prev & ~cs_sync;

  assign cmd_next  = {cmd_sr, io0_sync};
  assign addr_next = {addr_sr, io0_sync};
  assign word_next = word_addr + 1'b1;

  // An odd start address streams only the low byte of the first word.
  assign load_word   = odd_first ? {prefetch[7:0], 8'h00} : prefetch;
  assign load_remain = dual ? (odd_first ? 4'd3 : 4'd7) : (odd_first ? 4'd7 : 4'd15);

  assign busy       = (state != ST_IDLE);
  assign spi_io1_oe = (state == ST_DATA);
  assign spi_io0_oe = (state == ST_DATA) & dual;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_prev   <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      io0_meta  <= 1'b0;
      io0_sync  <= 1'b0;
      io1_meta  <= 1'b0;
      io1_sync  <= 1'b0;
    end else begin
      cs_meta   <= spi_cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sclk_meta <= spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      io0_meta  <= spi_io0_i;
      io0_sync  <= io0_meta;
      io1_meta  <= spi_io1_i;
      io1_sync  <= io1_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 5'd0;
      cmd_sr     <= 7'd0;
      addr_sr    <= '0;
      dual       <= 1'b0;
      odd_first  <= 1'b0;
      word_addr  <= '0;
      prefetch   <= 16'd0;
      shift      <= 16'd0;
      remain     <= 4'd0;
      rd_pending <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      spi_io0_o  <= 1'b0;
      spi_io1_o  <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      rd_pending <= mem_re;
      if (rd_pending) prefetch <= mem_rdata;

      if (state != ST_IDLE && cs_sync) begin
        state     <= ST_IDLE;
        spi_io0_o <= 1'b0;
        spi_io1_o <= 1'b0;
        remain    <= 4'd0;
        odd_first <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= 5'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr  <= cmd_next[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                if (cmd_next == 8'h03) begin
                  dual  <= 1'b0;
                  state <= ST_ADDR;
                end else if (cmd_next == 8'h3B) begin
                  dual  <= 1'b1;
                  state <= ST_ADDR;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              addr_sr <= addr_next[MEM_AW-1:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt   <= 5'd0;
                mem_re    <= 1'b1;
                mem_addr  <= addr_next[MEM_AW:1];
                word_addr <= addr_next[MEM_AW:1];
                odd_first <= addr_next[0];
                remain    <= 4'd0;
                state     <= dual ? ST_DUMMY : ST_DATA;
              end
            end
          end
          ST_DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                state   <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              if (remain == 4'd0) begin
                // New word goes out; fetch its successor into the prefetch slot.
                spi_io1_o <= load_word[15];
                spi_io0_o <= dual & load_word[14];
                shift     <= dual ? {load_word[13:0], 2'b00} : {load_word[14:0], 1'b0};
                remain    <= load_remain;
                odd_first <= 1'b0;
                word_addr <= word_next;
                mem_re    <= 1'b1;
                mem_addr  <= word_next;
              end else begin
                spi_io1_o <= shift[15];
                spi_io0_o <= dual & shift[14];
                shift     <= dual ? {shift[13:0], 2'b00} : {shift[14:0], 1'b0};
                remain    <= remain - 4'd1;
              end
            end
          end
          ST_IGNORE: begin
            state <= ST_IGNORE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
